// File: rtl/counter_bank_pkg.sv
// Shared types and constants for the multi-channel counter bank.
// COUNTER_BANK_PRESCALE_EN compiles in the shared tick prescaler.
package counter_bank_pkg;

    typedef enum logic [2:0] {
        OP_NOP          = 3'd0,
        OP_LOAD         = 3'd1,
        OP_SET_CMP      = 3'd2,
        OP_SET_MODE     = 3'd3,
        OP_READ         = 3'd4,
        OP_CLEAR        = 3'd5,
        OP_SET_PRESCALE = 3'd6,
        OP_RSVD         = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        DIR_STOP = 2'b00,
        DIR_UP   = 2'b01,
        DIR_DOWN = 2'b10
    } dir_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_e;

    // Compare registers reset to all-ones; replicated to any WIDTH.
    localparam logic CMP_RST_FILL = 1'b1;

endpackage

// File: rtl/counter_bank_channel.sv
// One counter channel: count, compare, mode, saturation, match and wrap.
// Build option COUNTER_BANK_PRESCALE_EN has no effect inside a channel.
module counter_bank_channel
    import counter_bank_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    input  logic             clr,
    input  logic             set_cmp,
    input  logic             set_mode,
    output logic [WIDTH-1:0] count,
    output logic             match,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ONES = '1;

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] cmp_q, cmp_d;
    dir_e             dir_q, dir_d;
    logic             sat_q, sat_d;
    logic             match_q, wrap_q, wrap_d;
    logic [2:0]       mode_bits;

    assign mode_bits = 3'(ld_val);

    always_comb begin
        cnt_d  = cnt_q;
        cmp_d  = cmp_q;
        dir_d  = dir_q;
        sat_d  = sat_q;
        wrap_d = 1'b0;
        // Command writes take priority over the tick step.
        if (ld) begin
            cnt_d = ld_val;
        end else if (clr) begin
            cnt_d = '0;
        end else if (tick && dir_q == DIR_UP) begin
            if (cnt_q != ONES) begin
                cnt_d = cnt_q + WIDTH'(1);
            end else if (!sat_q) begin
                cnt_d  = '0;
                wrap_d = 1'b1;
            end
        end else if (tick && dir_q == DIR_DOWN) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - WIDTH'(1);
            end else if (!sat_q) begin
                cnt_d  = ONES;
                wrap_d = 1'b1;
            end
        end
        if (set_cmp) begin
            cmp_d = ld_val;
        end
        if (set_mode) begin
            unique case (mode_bits[1:0])
                2'b01:   dir_d = DIR_UP;
                2'b10:   dir_d = DIR_DOWN;
                default: dir_d = DIR_STOP;
            endcase
            sat_d = mode_bits[2];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            cmp_q   <= {WIDTH{CMP_RST_FILL}};
            dir_q   <= DIR_STOP;
            sat_q   <= 1'b0;
            match_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            cmp_q   <= cmp_d;
            dir_q   <= dir_d;
            sat_q   <= sat_d;
            match_q <= (cnt_d == cmp_d);
            wrap_q  <= wrap_d;
        end
    end

    assign count = cnt_q;
    assign match = match_q;
    assign wrap  = wrap_q;

endmodule

// File: rtl/counter_bank.sv
// Counter bank top: command FSM, optional prescaler, read mux, channels.
// Define COUNTER_BANK_PRESCALE_EN to compile in the tick prescaler.
module counter_bank
    import counter_bank_pkg::*;
#(
    parameter  int WIDTH      = 8,
    parameter  int CHANNELS   = 4,
    parameter  int PRESCALE_W = 8,
    localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ena,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [2:0]                cmd_op,
    input  logic [CH_W-1:0]           cmd_ch,
    input  logic [WIDTH-1:0]          cmd_data,
    output logic                      rd_valid,
    output logic [WIDTH-1:0]          rd_data,
    output logic [CHANNELS*WIDTH-1:0] cnt_flat,
    output logic [CHANNELS-1:0]       match,
    output logic [CHANNELS-1:0]       wrap
);

    state_e           state_q, state_d;
    op_e              op_q;
    logic [CH_W-1:0]  ch_q;
    logic [WIDTH-1:0] data_q;
    logic             rd_valid_q, rd_valid_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic [WIDTH-1:0] rd_mux;
    logic [WIDTH-1:0] cnt [CHANNELS];
    logic             exec, ch_ok, tick;

    assign cmd_ready = (state_q == ST_IDLE);
    assign exec      = (state_q == ST_EXEC);
    // Out-of-range channels accept the command but touch nothing.
    assign ch_ok     = ({1'b0, ch_q} < (CH_W+1)'(CHANNELS));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (cmd_valid) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_NOP;
            ch_q    <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (cmd_valid && cmd_ready) begin
                op_q   <= op_e'(cmd_op);
                ch_q   <= cmd_ch;
                data_q <= cmd_data;
            end
        end
    end

`ifdef COUNTER_BANK_PRESCALE_EN
    logic [PRESCALE_W-1:0] psc_cnt_q, psc_cnt_d;
    logic [PRESCALE_W-1:0] psc_rld_q, psc_rld_d;

    assign tick = ena && (psc_cnt_q == psc_rld_q);

    always_comb begin
        psc_cnt_d = psc_cnt_q;
        psc_rld_d = psc_rld_q;
        if (exec && ch_ok && op_q == OP_SET_PRESCALE) begin
            psc_rld_d = PRESCALE_W'(data_q);
            psc_cnt_d = '0;
        end else if (ena) begin
            psc_cnt_d = tick ? '0 : psc_cnt_q + PRESCALE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            psc_cnt_q <= '0;
            psc_rld_q <= '0;
        end else begin
            psc_cnt_q <= psc_cnt_d;
            psc_rld_q <= psc_rld_d;
        end
    end
`else
    logic [PRESCALE_W-1:0] unused_psc;
    assign unused_psc = '0;
    assign tick       = ena;
`endif

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (ch_q == CH_W'(i)) rd_mux = cnt[i];
        end
    end

    // READ samples the count before this cycle's update.
    always_comb begin
        rd_valid_d = exec && (op_q == OP_READ);
        rd_data_d  = rd_data_q;
        if (rd_valid_d) rd_data_d = ch_ok ? rd_mux : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic hit;
        assign hit = exec && (ch_q == CH_W'(g));

        counter_bank_channel #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .tick    (tick),
            .ld      (hit && op_q == OP_LOAD),
            .ld_val  (data_q),
            .clr     (hit && op_q == OP_CLEAR),
            .set_cmp (hit && op_q == OP_SET_CMP),
            .set_mode(hit && op_q == OP_SET_MODE),
            .count   (cnt[g]),
            .match   (match[g]),
            .wrap    (wrap[g])
        );

        assign cnt_flat[g*WIDTH +: WIDTH] = cnt[g];
    end

endmodule

// File: tb/tb_counter_bank.sv
// Self-checking bench for counter_bank against a cycle-level behavioural model.
// Honours COUNTER_BANK_PRESCALE_EN the same way as the design.
module tb_counter_bank;

    localparam int W    = 8;
    localparam int N    = 4;
    localparam int CHW  = 2;
    localparam int PW   = 8;
    localparam int MAXV = 255;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           ena = 1'b0;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic [2:0]     cmd_op = '0;
    logic [CHW-1:0] cmd_ch = '0;
    logic [W-1:0]   cmd_data = '0;
    logic           rd_valid;
    logic [W-1:0]   rd_data;
    logic [N*W-1:0] cnt_flat;
    logic [N-1:0]   match;
    logic [N-1:0]   wrap;

    int checks = 0;
    int failures = 0;

    int m_cnt [N];
    int m_cmp [N];
    int m_dir [N];
    bit m_sat [N];
    bit m_wrap[N];
    bit m_busy, m_rdv;
    int m_op, m_ch, m_data, m_rdd, m_prl, m_pct;

    counter_bank #(
        .WIDTH(W), .CHANNELS(N), .PRESCALE_W(PW)
    ) dut (
        .clk(clk), .rst(rst), .ena(ena),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_ch(cmd_ch), .cmd_data(cmd_data),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .cnt_flat(cnt_flat), .match(match), .wrap(wrap)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    // Behavioural model: applies one clock edge worth of the block's rules.
    task automatic model_edge();
        bit tk;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_cnt[i] = 0; m_cmp[i] = MAXV; m_dir[i] = 0;
                m_sat[i] = 0; m_wrap[i] = 0;
            end
            m_busy = 0; m_rdv = 0; m_rdd = 0; m_prl = 0; m_pct = 0;
            return;
        end
        tk = ena && (m_pct == m_prl);
        m_rdv = m_busy && m_op == 4;
        if (m_rdv) m_rdd = (m_ch < N) ? m_cnt[m_ch] : 0;
        for (int i = 0; i < N; i++) begin
            bit hit;
            hit = m_busy && m_ch == i;
            m_wrap[i] = 0;
            if (hit && m_op == 1) m_cnt[i] = m_data;
            else if (hit && m_op == 5) m_cnt[i] = 0;
            else if (tk && m_dir[i] == 1) begin
                if (m_cnt[i] < MAXV) m_cnt[i]++;
                else if (!m_sat[i]) begin m_cnt[i] = 0; m_wrap[i] = 1; end
            end else if (tk && m_dir[i] == 2) begin
                if (m_cnt[i] > 0) m_cnt[i]--;
                else if (!m_sat[i]) begin m_cnt[i] = MAXV; m_wrap[i] = 1; end
            end
            if (hit && m_op == 2) m_cmp[i] = m_data;
            if (hit && m_op == 3) begin
                m_dir[i] = ((m_data % 4) == 3) ? 0 : (m_data % 4);
                m_sat[i] = ((m_data / 4) % 2) == 1;
            end
        end
        if (m_busy && m_op == 6) begin
`ifdef COUNTER_BANK_PRESCALE_EN
            m_prl = m_data;
            m_pct = 0;
`endif
        end else if (ena) begin
            m_pct = tk ? 0 : m_pct + 1;
        end
        if (m_busy) m_busy = 0;
        else if (cmd_valid) begin
            m_busy = 1;
            m_op = int'(cmd_op); m_ch = int'(cmd_ch); m_data = int'(cmd_data);
        end
    endtask

    function automatic logic [N*W-1:0] exp_flat();
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = W'(m_cnt[i]);
        return r;
    endfunction

    function automatic logic [N-1:0] exp_match();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = (m_cnt[i] == m_cmp[i]);
        return r;
    endfunction

    function automatic logic [N-1:0] exp_wrap();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = m_wrap[i];
        return r;
    endfunction

    task automatic advance();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic accept(input int op, input int ch, input int data);
        int n;
        n = 0;
        while (!cmd_ready && n < 8) begin advance(); n++; end
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_timeout got=%b exp=1", cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_op    = 3'(op);
        cmd_ch    = CHW'(ch);
        cmd_data  = W'(data);
        advance();
        cmd_valid = 1'b0;
        cmd_op    = '0;
    endtask

    task automatic send(input int op, input int ch, input int data);
        accept(op, ch, data);
        advance();
    endtask

    task automatic do_reset();
        rst = 1'b1; ena = 1'b0; cmd_valid = 1'b0;
        advance(); advance();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        advance(); advance();
        checks += 6;
        if (cnt_flat !== '0) begin failures++; $display("FAIL rst_cnt got=%h exp=0", cnt_flat); end
        if (match !== '0) begin failures++; $display("FAIL rst_match got=%b exp=0", match); end
        if (wrap !== '0) begin failures++; $display("FAIL rst_wrap got=%b exp=0", wrap); end
        if (cmd_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", cmd_ready); end
        if (rd_valid !== 1'b0) begin failures++; $display("FAIL rst_rdv got=%b exp=0", rd_valid); end
        if (rd_data !== '0) begin failures++; $display("FAIL rst_rdd got=%h exp=0", rd_data); end
        rst = 1'b0;
        accept(4, 0, 0);
        checks += 2;
        if (rd_valid !== 1'b0) begin failures++; $display("FAIL read_early got=%b exp=0", rd_valid); end
        if (cmd_ready !== 1'b0) begin failures++; $display("FAIL exec_ready got=%b exp=0", cmd_ready); end
        advance();
        checks += 2;
        if (rd_valid !== 1'b1) begin failures++; $display("FAIL read_valid got=%b exp=1", rd_valid); end
        if (rd_data !== 8'h00) begin failures++; $display("FAIL read_data got=%h exp=00", rd_data); end
        advance();
        checks++;
        if (rd_valid !== 1'b0) begin failures++; $display("FAIL read_pulse got=%b exp=0", rd_valid); end
    endtask

    task automatic test_wrap();
        logic [7:0] seq [4];
        int pulses;
        seq[0] = 8'hFF; seq[1] = 8'h00; seq[2] = 8'h01; seq[3] = 8'h02;
        pulses = 0;
        do_reset();
        send(1, 1, 8'hFE);
        send(3, 1, 1);
        ena = 1'b1;
        for (int k = 0; k < 4; k++) begin
            advance();
            pulses += int'(wrap[1]);
            checks += 3;
            if (cnt_flat[15:8] !== seq[k]) begin
                failures++; $display("FAIL wrap_cnt k=%0d got=%h exp=%h", k, cnt_flat[15:8], seq[k]);
            end
            if (wrap[1] !== (seq[k] == 8'h00)) begin
                failures++; $display("FAIL wrap_pulse k=%0d got=%b exp=%b", k, wrap[1], seq[k] == 8'h00);
            end
            if (cnt_flat !== exp_flat()) begin
                failures++; $display("FAIL wrap_flat got=%h exp=%h", cnt_flat, exp_flat());
            end
        end
        checks++;
        if (pulses != 1) begin failures++; $display("FAIL wrap_once got=%0d exp=1", pulses); end
        ena = 1'b0;
    endtask

    task automatic test_saturate();
        do_reset();
        send(1, 2, 8'h01);
        send(3, 2, 3'b110);
        ena = 1'b1;
        for (int k = 0; k < 5; k++) begin
            advance();
            checks += 2;
            if (wrap[2] !== 1'b0) begin failures++; $display("FAIL sat_wrap k=%0d got=%b exp=0", k, wrap[2]); end
            if (cnt_flat[23:16] !== 8'h00) begin
                failures++; $display("FAIL sat_cnt k=%0d got=%h exp=00", k, cnt_flat[23:16]);
            end
        end
        ena = 1'b0;
    endtask

    task automatic test_match();
        do_reset();
        send(2, 0, 8'h05);
        send(3, 0, 1);
        ena = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            advance();
            checks += 4;
            if (cnt_flat[7:0] !== 8'(k)) begin
                failures++; $display("FAIL match_cnt got=%h exp=%h", cnt_flat[7:0], 8'(k));
            end
            if (match[0] !== (k == 5)) begin
                failures++; $display("FAIL match0 k=%0d got=%b exp=%b", k, match[0], k == 5);
            end
            if (cnt_flat !== exp_flat()) begin
                failures++; $display("FAIL match_flat got=%h exp=%h", cnt_flat, exp_flat());
            end
            if (match !== exp_match()) begin
                failures++; $display("FAIL match_all got=%b exp=%b", match, exp_match());
            end
        end
        ena = 1'b0;
    endtask

    task automatic test_collision();
        logic [7:0] c0;
        do_reset();
        send(3, 3, 1);
        send(3, 0, 1);
        ena = 1'b1;
        advance(); advance(); advance();
        accept(1, 3, 8'h40);
        c0 = 8'(m_cnt[0] + 1);
        advance();
        checks += 2;
        if (cnt_flat[31:24] !== 8'h40) begin failures++; $display("FAIL coll_ld got=%h exp=40", cnt_flat[31:24]); end
        if (cnt_flat[7:0] !== c0) begin failures++; $display("FAIL coll_other got=%h exp=%h", cnt_flat[7:0], c0); end
        advance();
        checks++;
        if (cnt_flat[31:24] !== 8'h41) begin failures++; $display("FAIL coll_next got=%h exp=41", cnt_flat[31:24]); end
        ena = 1'b0;
    endtask

    task automatic test_prescale();
        logic [7:0] want;
`ifdef COUNTER_BANK_PRESCALE_EN
        want = 8'd3;
`else
        want = 8'd12;
`endif
        do_reset();
        send(6, 0, 3);
        send(3, 0, 1);
        ena = 1'b1;
        for (int k = 0; k < 12; k++) begin
            advance();
            checks++;
            if (cnt_flat !== exp_flat()) begin
                failures++; $display("FAIL psc_flat got=%h exp=%h", cnt_flat, exp_flat());
            end
        end
        ena = 1'b0;
        checks++;
        if (cnt_flat[7:0] !== want) begin failures++; $display("FAIL psc_adv got=%0d exp=%0d", cnt_flat[7:0], want); end
    endtask

    task automatic test_reset_exec();
        do_reset();
        accept(1, 0, 8'h55);
        rst = 1'b1;
        advance();
        rst = 1'b0;
        checks += 2;
        if (cnt_flat !== '0) begin failures++; $display("FAIL abort_ld got=%h exp=0", cnt_flat); end
        if (cmd_ready !== 1'b1) begin failures++; $display("FAIL abort_ready got=%b exp=1", cmd_ready); end
        accept(4, 0, 0);
        rst = 1'b1;
        advance();
        rst = 1'b0;
        checks++;
        if (rd_valid !== 1'b0) begin failures++; $display("FAIL abort_rd got=%b exp=0", rd_valid); end
    endtask

    task automatic test_random();
        logic [7:0] edges [4];
        edges[0] = 8'h00; edges[1] = 8'h01; edges[2] = 8'hFE; edges[3] = 8'hFF;
        do_reset();
        for (int k = 0; k < 600; k++) begin
            rst       = ($urandom_range(0, 149) == 0);
            ena       = ($urandom_range(0, 3) != 0);
            cmd_valid = $urandom_range(0, 1) == 1;
            cmd_op    = 3'($urandom_range(0, 7));
            cmd_ch    = CHW'($urandom_range(0, N - 1));
            cmd_data  = W'($urandom);
            if ($urandom_range(0, 2) == 0) cmd_data = edges[$urandom_range(0, 3)];
            if (cmd_op == 3'd6) cmd_data = W'($urandom_range(0, 3));
            advance();
            checks += 6;
            if (cnt_flat !== exp_flat()) begin failures++; $display("FAIL rnd_cnt k=%0d got=%h exp=%h", k, cnt_flat, exp_flat()); end
            if (match !== exp_match()) begin failures++; $display("FAIL rnd_match k=%0d got=%b exp=%b", k, match, exp_match()); end
            if (wrap !== exp_wrap()) begin failures++; $display("FAIL rnd_wrap k=%0d got=%b exp=%b", k, wrap, exp_wrap()); end
            if (cmd_ready !== !m_busy) begin failures++; $display("FAIL rnd_ready k=%0d got=%b exp=%b", k, cmd_ready, !m_busy); end
            if (rd_valid !== m_rdv) begin failures++; $display("FAIL rnd_rdv k=%0d got=%b exp=%b", k, rd_valid, m_rdv); end
            if (rd_data !== W'(m_rdd)) begin failures++; $display("FAIL rnd_rdd k=%0d got=%h exp=%h", k, rd_data, W'(m_rdd)); end
        end
        rst = 1'b0; ena = 1'b0; cmd_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_saturate();
        test_match();
        test_collision();
        test_prescale();
        test_reset_exec();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
